joy_db9_scanner: RTL and testbench
==================================

JOY_DB9_SCANNER -- requirements
Module: joy_db9_scanner

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 8: number of clk cycles per tick (legal range 2..255).
REQ-002 The module SHALL have parameter SCAN_GAP, default 1000: number of idle ticks between scans (legal range 1..65535).
REQ-003 Port clk  input  1  system clock (clk50mhz domain); all logic rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  scan enable; when low, no new scan starts.
REQ-006 Port joy_clk  output  1  shift clock to external 74HC165 chain.
REQ-007 Port joy_load_n  output  1  parallel-load strobe to the chain, active low.
REQ-008 Port joy_data  input  1  serial data from the chain; buttons are active low.
REQ-009 Port joy1  output  8  debounced joystick 1 state, 1 = pressed.
REQ-010 Port joy2  output  8  debounced joystick 2 state, 1 = pressed.
REQ-011 Port scan_done  output  1  one-clk pulse at the end of every completed scan.
REQ-012 Port changed  output  1  one-clk pulse when joy1 or joy2 takes a new value.

Function
REQ-013 Tick: a divider SHALL count 0..CLK_DIV-1 and assert an internal tick for one clk when it reaches CLK_DIV-1; the divider free-runs.
REQ-014 The FSM SHALL have states IDLE, LOAD, LOW, HIGH and GAP, and SHALL change state only on tick.
REQ-015 IDLE: joy_load_n=1, joy_clk=0; on tick with enable=1, go to LOAD.
REQ-016 LOAD: joy_load_n=0 for exactly one tick period; on tick, go to LOW with bit counter=0.
REQ-017 LOW: joy_clk=0; on the tick leaving LOW, sample joy_data into shift register bit 15-counter, then go to HIGH.
REQ-018 HIGH: joy_clk=1; on tick, if counter=15 go to GAP and complete the scan, else counter+1 and go to LOW.
REQ-019 Scan length SHALL be 1+32 ticks (LOAD + 16x(LOW+HIGH)), i.e. 33*CLK_DIV clk cycles.
REQ-020 Word mapping: the first sampled bit SHALL be bit 15; raw joy1=~sr[15:8] and raw joy2=~sr[7:0].
REQ-021 Scan completion SHALL pulse scan_done one clk after the final HIGH tick.
REQ-022 Debounce: raw word compared with previous scan's raw word; joy1/joy2 SHALL update only when the two are equal, in the same clk as scan_done.
REQ-023 changed SHALL pulse in the same clk as scan_done only when the debounced value actually differs from the held value.
REQ-024 GAP: outputs idle (joy_clk=0, joy_load_n=1) for SCAN_GAP ticks, then go to LOAD if enable=1, else IDLE.
REQ-025 enable deasserted during LOAD/LOW/HIGH SHALL abort at the next tick to IDLE: no scan_done, no output update, previous raw word discarded (the next scan cannot qualify debounce).
REQ-026 joy_clk and joy_load_n SHALL be registered outputs, glitch-free, never low/high simultaneously in a way that loads while shifting (joy_load_n=0 implies joy_clk=0).

Reset
REQ-027 On reset assertion, immediately: state=IDLE, divider=0, counter=0, shift register=16'hFFFF, previous raw word invalid, joy_clk=0, joy_load_n=1, joy1=0, joy2=0, scan_done=0, changed=0.
REQ-028 Reset asserted mid-scan SHALL behave identically to reset from IDLE; first scan after release cannot update outputs (needs two matching scans).

Verification
REQ-029 CLK_DIV=4, SCAN_GAP=2, joy_data model all-high (no buttons), enable=1 -> scan_done every (33+2)*4 clk after the first scan, joy1=joy2=8'h00, changed never pulses.
REQ-030 Model chain presenting 16'h7FFE (joy1 bit7 and joy2 bit0 pressed) -> first scan: no update; second scan: joy1=8'h80, joy2=8'h01, changed=1 with scan_done.
REQ-031 Model alternating 16'h0000 / 16'hFFFF each scan -> joy1/joy2 stay 8'h00, changed never pulses (debounce rejects).
REQ-032 Deassert enable at bit 8 of a scan -> FSM returns to IDLE within 4 clk, joy_clk=0, joy_load_n=1, no scan_done; re-enable -> two full scans required before update.
REQ-033 Assert reset for 1 clk during HIGH state -> outputs reach reset values asynchronously; after release, LOAD occurs on the first tick with enable=1.
REQ-034 Check joy_load_n low width equals exactly CLK_DIV clk, joy_clk high/low widths equal CLK_DIV clk each, and exactly 16 rising joy_clk edges per scan.

Source files
------------

// File: rtl/joy_db9_scanner.sv
// Scanner for a 16-bit 74HC165 chain carrying two 8-button DB9 joysticks.
// Generates load/shift strobes from a tick divider and debounces across two scans.
module joy_db9_scanner #(
    parameter int CLK_DIV  = 8,
    parameter int SCAN_GAP = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       joy_clk,
    output logic       joy_load_n,
    input  logic       joy_data,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       scan_done,
    output logic       changed
);

    localparam logic [7:0]  DIV_MAX = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_MAX = 16'(SCAN_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] sr_q, sr_d;
    logic [15:0] prev_q, prev_d;
    logic        prev_vld_q, prev_vld_d;
    logic [7:0]  joy1_q, joy1_d, joy2_q, joy2_d;
    logic        done_q, done_d, chg_q, chg_d;
    logic        jclk_q, jclk_d, jload_n_q, jload_n_d;
    logic        tick;
    logic [15:0] raw;

    assign tick = (div_q == DIV_MAX);
    // Buttons are active low on the chain.
    assign raw  = ~sr_q;

    always_comb begin
        state_d    = state_q;
        div_d      = tick ? 8'd0 : div_q + 8'd1;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sr_d       = sr_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        joy1_d     = joy1_q;
        joy2_d     = joy2_q;
        done_d     = 1'b0;
        chg_d      = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: if (enable) state_d = S_LOAD;
                S_LOAD: begin
                    if (!enable) begin
                        state_d    = S_IDLE;
                        prev_vld_d = 1'b0;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = 4'd0;
                    end
                end
                S_LOW: begin
                    if (!enable) begin
                        state_d    = S_IDLE;
                        prev_vld_d = 1'b0;
                    end else begin
                        sr_d[4'd15 - bit_q] = joy_data;
                        state_d             = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (!enable) begin
                        state_d    = S_IDLE;
                        prev_vld_d = 1'b0;
                    end else if (bit_q == 4'd15) begin
                        state_d    = S_GAP;
                        gap_d      = 16'd0;
                        done_d     = 1'b1;
                        // Only a word seen identically on two consecutive scans is accepted.
                        if (prev_vld_q && raw == prev_q) begin
                            joy1_d = raw[15:8];
                            joy2_d = raw[7:0];
                            chg_d  = (raw != {joy1_q, joy2_q});
                        end
                        prev_d     = raw;
                        prev_vld_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = S_LOW;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_MAX) state_d = enable ? S_LOAD : S_IDLE;
                    else                  gap_d   = gap_q + 16'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Strobes are derived from the next state so they flip in the same edge as the FSM.
        jclk_d    = (state_d == S_HIGH);
        jload_n_d = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= 8'd0;
            bit_q      <= 4'd0;
            gap_q      <= 16'd0;
            sr_q       <= 16'hFFFF;
            prev_q     <= 16'd0;
            prev_vld_q <= 1'b0;
            joy1_q     <= 8'd0;
            joy2_q     <= 8'd0;
            done_q     <= 1'b0;
            chg_q      <= 1'b0;
            jclk_q     <= 1'b0;
            jload_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sr_q       <= sr_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            done_q     <= done_d;
            chg_q      <= chg_d;
            jclk_q     <= jclk_d;
            jload_n_q  <= jload_n_d;
        end
    end

    assign joy_clk    = jclk_q;
    assign joy_load_n = jload_n_q;
    assign joy1       = joy1_q;
    assign joy2       = joy2_q;
    assign scan_done  = done_q;
    assign changed    = chg_q;

endmodule

// File: tb/tb_joy_db9_scanner.sv
// Directed bench for joy_db9_scanner with a behavioural 74HC165 chain model.
module tb_joy_db9_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       joy_clk, joy_load_n, joy_data;
    logic [7:0] joy1, joy2;
    logic       scan_done, changed;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int chg_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic chg_at_done = 1'b0;

    logic [15:0] pat = 16'hFFFF;
    logic [15:0] sh = 16'hFFFF;
    logic        jprev = 1'b0;

    joy_db9_scanner #(.CLK_DIV(4), .SCAN_GAP(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .joy_clk(joy_clk), .joy_load_n(joy_load_n), .joy_data(joy_data),
        .joy1(joy1), .joy2(joy2), .scan_done(scan_done), .changed(changed)
    );

    always #5 clk = ~clk;

    // Chain: parallel load while load_n low, shift in ones on each rising joy_clk.
    assign joy_data = sh[15];
    always @(posedge clk) begin
        if (!joy_load_n)          sh <= pat;
        else if (joy_clk && !jprev) sh <= {sh[14:0], 1'b1};
        jprev <= joy_clk;
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        if (changed)   chg_cnt++;
        if (scan_done) done_cnt++;
    end

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < 600);
        checks++;
        if (!scan_done) begin
            failures++;
            $display("FAIL %s: no scan_done within %0d clk, pulse required", name, n);
        end
        chg_at_done = changed;
        done_cyc    = cyc;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({joy_clk, joy_load_n, joy1, joy2, scan_done, changed} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got clk=%b load_n=%b j1=%h j2=%h done=%b chg=%b, required 0 1 00 00 0 0",
                     joy_clk, joy_load_n, joy1, joy2, scan_done, changed);
        end
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_idle_chain;
        int t0, t1;
        pat = 16'hFFFF;
        wait_done("idle_first");
        t0 = done_cyc;
        wait_done("idle_second");
        t1 = done_cyc;
        checks++;
        if (t1 - t0 != 140) begin
            failures++;
            $display("FAIL idle_period: got %0d clk, required 140", t1 - t0);
        end
        wait_done("idle_third");
        checks++;
        if (done_cyc - t1 != 140) begin
            failures++;
            $display("FAIL idle_period2: got %0d clk, required 140", done_cyc - t1);
        end
        checks++;
        if (joy1 !== 8'h00 || joy2 !== 8'h00 || chg_cnt != 0) begin
            failures++;
            $display("FAIL idle_outputs: got j1=%h j2=%h changed_pulses=%0d, required 00 00 0", joy1, joy2, chg_cnt);
        end
    endtask

    task automatic test_strobe_timing;
        int ll = 0, rises = 0, hrun = 0, lrun = 0, bad = 0;
        int hmin = 999, hmax = 0, lmin = 999, lmax = 0;
        logic seen = 1'b0, pj = 1'b0;
        wait_done("timing_sync");
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (!joy_load_n) ll++;
            if (!joy_load_n && joy_clk) bad++;
            if (joy_clk && !pj) begin
                rises++;
                if (seen) begin
                    if (lrun < lmin) lmin = lrun;
                    if (lrun > lmax) lmax = lrun;
                end
                seen = 1'b1;
            end
            if (joy_clk) begin
                hrun++;
                lrun = 0;
            end else begin
                if (hrun > 0) begin
                    if (hrun < hmin) hmin = hrun;
                    if (hrun > hmax) hmax = hrun;
                end
                hrun = 0;
                lrun++;
            end
            pj = joy_clk;
        end
        checks++;
        if (ll != 4) begin
            failures++;
            $display("FAIL load_width: got %0d clk, required 4", ll);
        end
        checks++;
        if (rises != 16) begin
            failures++;
            $display("FAIL clk_edges: got %0d rising edges, required 16", rises);
        end
        checks++;
        if (hmin != 4 || hmax != 4 || lmin != 4 || lmax != 4) begin
            failures++;
            $display("FAIL clk_widths: got high %0d..%0d low %0d..%0d, required 4", hmin, hmax, lmin, lmax);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL load_while_shift: got %0d clk with load_n=0 and joy_clk=1, required 0", bad);
        end
    endtask

    task automatic test_press;
        pat = 16'h7FFE;
        wait_done("press_scan1");
        checks++;
        if (joy1 !== 8'h00 || joy2 !== 8'h00 || chg_at_done !== 1'b0) begin
            failures++;
            $display("FAIL press_first: got j1=%h j2=%h chg=%b, required 00 00 0", joy1, joy2, chg_at_done);
        end
        wait_done("press_scan2");
        checks++;
        if (joy1 !== 8'h80 || joy2 !== 8'h01 || chg_at_done !== 1'b1) begin
            failures++;
            $display("FAIL press_second: got j1=%h j2=%h chg=%b, required 80 01 1", joy1, joy2, chg_at_done);
        end
        wait_done("press_scan3");
        checks++;
        if (joy1 !== 8'h80 || joy2 !== 8'h01 || chg_at_done !== 1'b0) begin
            failures++;
            $display("FAIL press_hold: got j1=%h j2=%h chg=%b, required 80 01 0", joy1, joy2, chg_at_done);
        end
    endtask

    task automatic test_abort;
        int r = 0, n = 0, d0, bad = 0;
        logic pj = 1'b0;
        pat = 16'hFFFF;
        wait_done("abort_prime");
        checks++;
        if (joy1 !== 8'h80 || joy2 !== 8'h01) begin
            failures++;
            $display("FAIL abort_prime: got j1=%h j2=%h, required 80 01", joy1, joy2);
        end
        while (r < 8 && n < 300) begin
            @(negedge clk);
            n++;
            if (joy_clk && !pj) r++;
            pj = joy_clk;
        end
        enable = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (joy_clk !== 1'b0 || joy_load_n !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle: got joy_clk=%b load_n=%b, required 0 1", joy_clk, joy_load_n);
        end
        d0 = done_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (joy_clk !== 1'b0 || joy_load_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active clk, %0d scan_done, required 0 0", bad, done_cnt - d0);
        end
        enable = 1'b1;
        wait_done("reenable_scan1");
        checks++;
        if (joy1 !== 8'h80 || joy2 !== 8'h01 || chg_at_done !== 1'b0) begin
            failures++;
            $display("FAIL reenable_first: got j1=%h j2=%h chg=%b, required 80 01 0", joy1, joy2, chg_at_done);
        end
        wait_done("reenable_scan2");
        checks++;
        if (joy1 !== 8'h00 || joy2 !== 8'h00 || chg_at_done !== 1'b1) begin
            failures++;
            $display("FAIL reenable_second: got j1=%h j2=%h chg=%b, required 00 00 1", joy1, joy2, chg_at_done);
        end
    endtask

    task automatic test_alternate;
        int c0 = chg_cnt;
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            pat = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
            wait_done("alt_scan");
            if (chg_at_done !== 1'b0 || joy1 !== 8'h00 || joy2 !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL alt_scans: got %0d scans with update/changed, required 0", bad);
        end
        @(posedge clk);
        #3;
        checks++;
        if (chg_cnt != c0 || joy1 !== 8'h00 || joy2 !== 8'h00) begin
            failures++;
            $display("FAIL alt_final: got j1=%h j2=%h changed_pulses=%0d, required 00 00 0", joy1, joy2, chg_cnt - c0);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        pat = 16'h7FFE;
        wait_done("rst_prime1");
        wait_done("rst_prime2");
        checks++;
        if (joy1 !== 8'h80 || joy2 !== 8'h01) begin
            failures++;
            $display("FAIL rst_prime: got j1=%h j2=%h, required 80 01", joy1, joy2);
        end
        while (joy_clk !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({joy_clk, joy_load_n, joy1, joy2, scan_done, changed} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_async: got clk=%b load_n=%b j1=%h j2=%h done=%b chg=%b, required 0 1 00 00 0 0",
                     joy_clk, joy_load_n, joy1, joy2, scan_done, changed);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (joy_load_n && n < 20);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL rst_first_load: got load after %0d clk, required 4", n);
        end
        wait_done("rst_scan1");
        checks++;
        if (joy1 !== 8'h00 || joy2 !== 8'h00 || chg_at_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_scan1: got j1=%h j2=%h chg=%b, required 00 00 0", joy1, joy2, chg_at_done);
        end
        wait_done("rst_scan2");
        checks++;
        if (joy1 !== 8'h80 || joy2 !== 8'h01 || chg_at_done !== 1'b1) begin
            failures++;
            $display("FAIL rst_scan2: got j1=%h j2=%h chg=%b, required 80 01 1", joy1, joy2, chg_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_idle_chain();
        test_strobe_timing();
        test_press();
        test_abort();
        test_alternate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
